// File: rtl/load_return_unit_pkg.sv
// Shared types for the load/return unit.
//   Uop          : micro-op encoding from execute; UOP_LDR selects the load path
//   region_e     : address region produced by the load address decoder
//   lru_state_e  : load/return unit FSM state
package load_return_unit_pkg;

    localparam int UOP_W = 3;

    typedef enum logic [UOP_W-1:0] {
        UOP_NOP = 3'd0,
        UOP_ADD = 3'd1,
        UOP_SUB = 3'd2,
        UOP_AND = 3'd3,
        UOP_OR  = 3'd4,
        UOP_XOR = 3'd5,
        UOP_STR = 3'd6,
        UOP_LDR = 3'd7
    } Uop;

    typedef enum logic [1:0] {
        REG_DCACHE   = 2'd0,
        REG_PERIPH   = 2'd1,
        REG_UNMAPPED = 2'd2
    } region_e;

    typedef enum logic {
        LRU_IDLE = 1'b0,
        LRU_WAIT = 1'b1
    } lru_state_e;

endpackage

// File: rtl/load_return_unit_addr_region_decode.sv
// Combinational load address decoder.
//   addr_i       : word address
//   region_o     : DCACHE (addr < DCACHE_WORDS), else PERIPH, else UNMAPPED
//   periph_idx_o : channel index addr - PERIPH_BASE (meaningful only for PERIPH)
module addr_region_decode
    import load_return_unit_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] DCACHE_WORDS = 31,
    parameter logic [ADDR_W-1:0] PERIPH_BASE  = 31,
    parameter int                N_PERIPH     = 4,
    parameter int                PIDX_W       = 2
) (
    input  logic [ADDR_W-1:0] addr_i,
    output region_e           region_o,
    output logic [PIDX_W-1:0] periph_idx_o
);

    // One extra bit so a peripheral window ending at the top of the
    // address space does not wrap around to zero.
    logic [ADDR_W:0] periph_end;
    assign periph_end = {1'b0, PERIPH_BASE} + (ADDR_W+1)'(N_PERIPH);

    always_comb begin
        region_o = REG_UNMAPPED;
        if (addr_i < DCACHE_WORDS) begin
            region_o = REG_DCACHE;
        end else if ((addr_i >= PERIPH_BASE) && ({1'b0, addr_i} < periph_end)) begin
            region_o = REG_PERIPH;
        end
    end

    assign periph_idx_o = PIDX_W'(addr_i - PERIPH_BASE);

endmodule

// File: rtl/load_return_unit.sv
// Register-writeback source selector with multi-cycle D-cache load support.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : uop handshake (ready only in IDLE)
//   uop, addr, rd_idx, alu   : uop, load word address, destination, ALU result
//   dcache_req/addr          : one-cycle read request and its registered address
//   dcache_rvalid/rdata      : D-cache read response
//   periph_rdata             : N_PERIPH packed peripheral read channels
//   wb_valid/idx/data        : one-cycle writeback strobe to the register file
//   stall                    : front-end stall, ~in_ready
//   bus_error                : pulses with wb_valid on unmapped address or timeout
module load_return_unit
    import load_return_unit_pkg::*;
#(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] DCACHE_WORDS = 31,
    parameter logic [ADDR_W-1:0] PERIPH_BASE  = 31,
    parameter int                N_PERIPH     = 4,
    parameter int                REG_IDX_W    = 4,
    parameter int                TIMEOUT      = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [UOP_W-1:0]           uop,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [REG_IDX_W-1:0]       rd_idx,
    input  logic [DATA_W-1:0]          alu,
    output logic                       dcache_req,
    output logic [ADDR_W-1:0]          dcache_addr,
    input  logic                       dcache_rvalid,
    input  logic [DATA_W-1:0]          dcache_rdata,
    input  logic [N_PERIPH*DATA_W-1:0] periph_rdata,
    output logic                       wb_valid,
    output logic [REG_IDX_W-1:0]       wb_idx,
    output logic [DATA_W-1:0]          wb_data,
    output logic                       stall,
    output logic                       bus_error
);

    localparam int PIDX_W = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    lru_state_e           state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [REG_IDX_W-1:0] wb_idx_q, wb_idx_d;
    logic [DATA_W-1:0]    wb_data_q, wb_data_d;
    logic                 bus_error_q, bus_error_d;
    logic                 dcache_req_q, dcache_req_d;
    logic [ADDR_W-1:0]    dcache_addr_q, dcache_addr_d;
    logic [REG_IDX_W-1:0] ld_idx_q, ld_idx_d;

    region_e              region;
    logic [PIDX_W-1:0]    periph_idx;
    logic [DATA_W-1:0]    periph_word;
    logic                 accept;

    addr_region_decode #(
        .ADDR_W       (ADDR_W),
        .DCACHE_WORDS (DCACHE_WORDS),
        .PERIPH_BASE  (PERIPH_BASE),
        .N_PERIPH     (N_PERIPH),
        .PIDX_W       (PIDX_W)
    ) u_decode (
        .addr_i       (addr),
        .region_o     (region),
        .periph_idx_o (periph_idx)
    );

    always_comb begin
        periph_word = '0;
        for (int k = 0; k < N_PERIPH; k++) begin
            if (periph_idx == PIDX_W'(k)) begin
                periph_word = periph_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign in_ready = (state_q == LRU_IDLE);
    assign accept   = in_valid & in_ready;

    // Next-state and output-register logic
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        wb_valid_d    = 1'b0;
        bus_error_d   = 1'b0;
        dcache_req_d  = 1'b0;
        wb_idx_d      = wb_idx_q;
        wb_data_d     = wb_data_q;
        dcache_addr_d = dcache_addr_q;
        ld_idx_d      = ld_idx_q;

        case (state_q)
            LRU_IDLE: begin
                if (accept) begin
                    if (uop != UOP_LDR) begin
                        wb_valid_d = 1'b1;
                        wb_idx_d   = rd_idx;
                        wb_data_d  = alu;
                    end else begin
                        case (region)
                            REG_DCACHE: begin
                                dcache_req_d  = 1'b1;
                                dcache_addr_d = addr;
                                ld_idx_d      = rd_idx;
                                timer_d       = '0;
                                state_d       = LRU_WAIT;
                            end
                            REG_PERIPH: begin
                                wb_valid_d = 1'b1;
                                wb_idx_d   = rd_idx;
                                wb_data_d  = periph_word;
                            end
                            default: begin
                                wb_valid_d  = 1'b1;
                                wb_idx_d    = rd_idx;
                                wb_data_d   = '0;
                                bus_error_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
            LRU_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A response arriving on the timeout cycle still counts.
                if (dcache_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_idx_d   = ld_idx_q;
                    wb_data_d  = dcache_rdata;
                    timer_d    = '0;
                    state_d    = LRU_IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    wb_valid_d  = 1'b1;
                    wb_idx_d    = ld_idx_q;
                    wb_data_d   = '0;
                    bus_error_d = 1'b1;
                    timer_d     = '0;
                    state_d     = LRU_IDLE;
                end
            end
            default: state_d = LRU_IDLE;
        endcase
    end

    // Register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LRU_IDLE;
            timer_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_idx_q      <= '0;
            wb_data_q     <= '0;
            bus_error_q   <= 1'b0;
            dcache_req_q  <= 1'b0;
            dcache_addr_q <= '0;
            ld_idx_q      <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            wb_valid_q    <= wb_valid_d;
            wb_idx_q      <= wb_idx_d;
            wb_data_q     <= wb_data_d;
            bus_error_q   <= bus_error_d;
            dcache_req_q  <= dcache_req_d;
            dcache_addr_q <= dcache_addr_d;
            ld_idx_q      <= ld_idx_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_idx      = wb_idx_q;
    assign wb_data     = wb_data_q;
    assign bus_error   = bus_error_q;
    assign dcache_req  = dcache_req_q;
    assign dcache_addr = dcache_addr_q;
    assign stall       = ~in_ready;

endmodule
